context_scheduler: RTL and testbench

Round-robin time-slice scheduler that sequences the program counter between up to NUM_PROC user processes. It counts non-halted user cycles and, when a quantum expires or a process finishes, issues a one-cycle `jump_context_exchange` pulse to the PC, which then vectors to the OS handler. It also records the interrupted process's PC and tells the OS handler which process to resume and at which address.

---
 rtl/context_scheduler.sv | 151 +++++++++++++++
 tb/tb_context_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/context_scheduler.sv
// Round-robin time-slice scheduler: counts non-halted user cycles, pulses the PC into the
// OS handler on quantum expiry or process exit, and tracks per-slot resume addresses.
module context_scheduler #(
   parameter int QUANTUM  = 64,
   parameter int NUM_PROC = 4,
   parameter int PC_WIDTH = 12
) (
   input  logic                        clock,
   input  logic                        resetCPU,
   input  logic                        enable,
   input  logic                        HLT,
   input  logic [PC_WIDTH-1:0]         programCounter,
   input  logic                        proc_load,
   input  logic [$clog2(NUM_PROC)-1:0] proc_load_id,
   input  logic [PC_WIDTH-1:0]         proc_load_pc,
   input  logic                        proc_done,
   input  logic                        os_resume,
   output logic                        jump_context_exchange,
   output logic [$clog2(NUM_PROC)-1:0] current_proc,
   output logic [$clog2(NUM_PROC)-1:0] next_proc,
   output logic [PC_WIDTH-1:0]         resume_pc,
   output logic [PC_WIDTH-1:0]         saved_pc,
   output logic [NUM_PROC-1:0]         active_mask,
   output logic                        idle,
   output logic [1:0]                  fsm_state
);

   localparam int IW = $clog2(NUM_PROC);
   localparam int CW = $clog2(QUANTUM);
   localparam logic [CW-1:0] LAST = CW'(QUANTUM - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_EXCH = 2'd2;
   localparam logic [1:0] S_WAIT = 2'd3;

   logic [1:0]          state, state_d;
   logic [CW-1:0]       count, count_d;
   logic [IW-1:0]       cur_d, next_d;
   logic [IW-1:0]       rr_pick, rr_idx, low_pick;
   logic                rr_found, low_found;
   logic [NUM_PROC-1:0] mask_d;
   logic [PC_WIDTH-1:0] saved_d;
   logic [PC_WIDTH-1:0] pc_table [NUM_PROC];
   logic                tick, done_ok, load_ok;

   assign tick      = enable && !HLT;
   assign done_ok   = proc_done && (state == S_RUN);
   // A slot that owns the CPU (or is being swapped out) cannot be reloaded under it.
   assign load_ok   = proc_load &&
                      !(((state == S_RUN) || (state == S_EXCH)) && (proc_load_id == current_proc));
   assign resume_pc = pc_table[next_proc];
   assign fsm_state = state;

   always_comb begin
      rr_pick  = current_proc;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int i = 1; i <= NUM_PROC; i++) begin
         rr_idx = current_proc + IW'(i);
         if (!rr_found && active_mask[rr_idx]) begin
            rr_pick  = rr_idx;
            rr_found = 1'b1;
         end
      end
      low_pick  = '0;
      low_found = 1'b0;
      for (int i = 0; i < NUM_PROC; i++) begin
         if (!low_found && active_mask[i]) begin
            low_pick  = IW'(i);
            low_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state;
      count_d = count;
      cur_d   = current_proc;
      next_d  = next_proc;
      saved_d = saved_pc;
      mask_d  = active_mask;
      if (done_ok) mask_d[current_proc] = 1'b0;
      if (load_ok) mask_d[proc_load_id] = 1'b1;
      case (state)
         S_IDLE: begin
            if (enable && (|active_mask)) begin
               next_d  = low_pick;
               state_d = S_WAIT;
            end
         end
         S_RUN: begin
            if ((tick && (count == LAST)) || done_ok) begin
               count_d = '0;
               state_d = S_EXCH;
            end else if (tick) begin
               count_d = count + CW'(1);
            end
         end
         S_EXCH: begin
            saved_d = programCounter;
            next_d  = rr_pick;
            state_d = S_WAIT;
         end
         default: begin
            if (os_resume) begin
               if (!enable || (active_mask == '0)) begin
                  state_d = S_IDLE;
               end else begin
                  cur_d   = next_proc;
                  count_d = '0;
                  state_d = S_RUN;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetCPU) begin
      if (!resetCPU) begin
         state                 <= S_IDLE;
         count                 <= '0;
         current_proc          <= '0;
         next_proc             <= '0;
         saved_pc              <= '0;
         active_mask           <= '0;
         jump_context_exchange <= 1'b0;
         idle                  <= 1'b1;
      end else begin
         state                 <= state_d;
         count                 <= count_d;
         current_proc          <= cur_d;
         next_proc             <= next_d;
         saved_pc              <= saved_d;
         active_mask           <= mask_d;
         jump_context_exchange <= (state_d == S_EXCH);
         idle                  <= (state_d == S_IDLE);
      end
   end

   // An exiting process has already lost its mask bit, so its table entry is left intact.
   always_ff @(posedge clock or negedge resetCPU) begin
      if (!resetCPU) begin
         for (int i = 0; i < NUM_PROC; i++) pc_table[i] <= '0;
      end else begin
         if (load_ok) pc_table[proc_load_id] <= proc_load_pc;
         if ((state == S_EXCH) && active_mask[current_proc]) pc_table[current_proc] <= programCounter;
      end
   end

endmodule

// File: tb/tb_context_scheduler.sv
// Directed bench for context_scheduler: a behavioural slot/slice model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_context_scheduler;

   localparam int QUANTUM  = 64;
   localparam int NUM_PROC = 4;
   localparam int PC_WIDTH = 12;

   logic                clock = 1'b0;
   logic                resetCPU;
   logic                enable, HLT, proc_load, proc_done, os_resume;
   logic [PC_WIDTH-1:0] programCounter, proc_load_pc;
   logic [1:0]          proc_load_id;
   logic                jump_context_exchange, idle;
   logic [1:0]          current_proc, next_proc, fsm_state;
   logic [PC_WIDTH-1:0] resume_pc, saved_pc;
   logic [3:0]          active_mask;

   int n_checks = 0;
   int n_fail   = 0;

   context_scheduler #(.QUANTUM(QUANTUM), .NUM_PROC(NUM_PROC), .PC_WIDTH(PC_WIDTH)) dut (
      .clock(clock), .resetCPU(resetCPU), .enable(enable), .HLT(HLT),
      .programCounter(programCounter), .proc_load(proc_load), .proc_load_id(proc_load_id),
      .proc_load_pc(proc_load_pc), .proc_done(proc_done), .os_resume(os_resume),
      .jump_context_exchange(jump_context_exchange), .current_proc(current_proc),
      .next_proc(next_proc), .resume_pc(resume_pc), .saved_pc(saved_pc),
      .active_mask(active_mask), .idle(idle), .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the CPU, how much of the slice is used, what the OS sees.
   typedef enum int {M_IDLE, M_OSWAIT, M_RUN, M_EXCH} mode_t;
   mode_t               m_mode;
   int                  m_used, m_cur, m_next;
   logic [3:0]          m_mask;
   logic [PC_WIDTH-1:0] m_saved;
   logic [PC_WIDTH-1:0] m_pc [NUM_PROC];

   function automatic int rr_search(input int cur);
      for (int k = 1; k <= NUM_PROC; k++) begin
         if (m_mask[(cur + k) % NUM_PROC]) return (cur + k) % NUM_PROC;
      end
      return cur;
   endfunction

   function automatic int lowest_live();
      for (int k = 0; k < NUM_PROC; k++) if (m_mask[k]) return k;
      return 0;
   endfunction

   task automatic model_step();
      bit load_ok;
      load_ok = proc_load && !(((m_mode == M_RUN) || (m_mode == M_EXCH)) && (int'(proc_load_id) == m_cur));
      case (m_mode)
         M_IDLE: if (enable && (m_mask != 0)) begin
            m_next = lowest_live();
            m_mode = M_OSWAIT;
         end
         M_RUN: begin
            if (enable && !HLT) m_used++;
            if (proc_done) m_mask[m_cur] = 1'b0;
            if (proc_done || (m_used == QUANTUM)) m_mode = M_EXCH;
         end
         M_EXCH: begin
            m_saved = programCounter;
            if (m_mask[m_cur]) m_pc[m_cur] = programCounter;
            m_next = rr_search(m_cur);
            m_mode = M_OSWAIT;
         end
         default: if (os_resume) begin
            if (!enable || (m_mask == 0)) m_mode = M_IDLE;
            else begin
               m_cur  = m_next;
               m_used = 0;
               m_mode = M_RUN;
            end
         end
      endcase
      if (load_ok) begin
         m_mask[proc_load_id] = 1'b1;
         m_pc[proc_load_id]   = proc_load_pc;
      end
   endtask

   always @(posedge clock or negedge resetCPU) begin
      if (!resetCPU) begin
         m_mode = M_IDLE; m_used = 0; m_cur = 0; m_next = 0; m_mask = '0; m_saved = '0;
         for (int i = 0; i < NUM_PROC; i++) m_pc[i] = '0;
      end else begin
         model_step();
      end
   end

   always @(negedge clock) begin
      check("cmp_pulse",       jump_context_exchange, (m_mode == M_EXCH) ? 1 : 0);
      check("cmp_idle",        idle,                  (m_mode == M_IDLE) ? 1 : 0);
      check("cmp_current",     current_proc,          m_cur);
      check("cmp_next",        next_proc,             m_next);
      check("cmp_mask",        active_mask,           m_mask);
      check("cmp_saved_pc",    saved_pc,              m_saved);
      check("cmp_resume_pc",   resume_pc,             m_pc[m_next]);
   end

   task automatic cyc();
      @(posedge clock);
      #2;
      programCounter = programCounter + 12'd1;
   endtask

   task automatic load(input logic [1:0] id, input logic [PC_WIDTH-1:0] pc);
      proc_load = 1'b1; proc_load_id = id; proc_load_pc = pc;
      cyc();
      proc_load = 1'b0;
   endtask

   task automatic resume();
      os_resume = 1'b1;
      cyc();
      os_resume = 1'b0;
   endtask

   task automatic wait_pulse(output int n);
      n = 0;
      while (!jump_context_exchange && (n < 300)) begin
         cyc();
         n++;
      end
      if (!jump_context_exchange) check("pulse_timeout", jump_context_exchange, 1);
   endtask

   int                  n, m;
   logic [PC_WIDTH-1:0] p, p1, p3;

   initial begin
      resetCPU = 1'b0; enable = 1'b0; HLT = 1'b0; proc_load = 1'b0; proc_load_id = '0;
      proc_load_pc = '0; proc_done = 1'b0; os_resume = 1'b0; programCounter = 12'h100;
      repeat (3) cyc();
      check("rst_idle", idle, 1);
      check("rst_pulse", jump_context_exchange, 0);
      check("rst_mask", active_mask, 0);
      check("rst_resume_pc", resume_pc, 0);
      resetCPU = 1'b1;
      cyc();

      // Quantum expiry from slot 0 to slot 1
      load(2'd0, 12'h010);
      load(2'd1, 12'h020);
      enable = 1'b1;
      cyc();
      check("boot_next", next_proc, 0);
      check("boot_resume_pc", resume_pc, 12'h010);
      resume();
      check("run_current", current_proc, 0);
      wait_pulse(n);
      check("quantum_len", n, 64);
      p = programCounter;
      cyc();
      check("quantum_saved_pc", saved_pc, p);
      check("quantum_next", next_proc, 1);
      check("quantum_resume_pc", resume_pc, 12'h020);
      check("quantum_pulse_width", jump_context_exchange, 0);

      // HLT freezes the slice count
      resume();
      n = 0;
      repeat (20) begin cyc(); n++; end
      HLT = 1'b1;
      repeat (10) begin cyc(); n++; end
      HLT = 1'b0;
      wait_pulse(m);
      check("hlt_delay", n + m, 74);
      cyc();
      check("hlt_next", next_proc, 0);

      // Wrap-around with slots 1 and 3 live
      load(2'd3, 12'h300);
      resume();
      proc_done = 1'b1;
      cyc();
      proc_done = 1'b0;
      check("done_pulse", jump_context_exchange, 1);
      cyc();
      check("done_next", next_proc, 1);
      resume();
      wait_pulse(n);
      p1 = programCounter;
      cyc();
      check("to3_next", next_proc, 3);
      check("to3_resume_pc", resume_pc, 12'h300);
      resume();
      wait_pulse(n);
      p3 = programCounter;
      cyc();
      check("wrap_next", next_proc, 1);
      check("wrap_resume_pc", resume_pc, p1);

      // Reloading the running slot is ignored; done coincides with the last counted cycle
      load(2'd0, 12'h0A0);
      resume();
      load(2'd1, 12'h777);
      check("load_current_ignored", active_mask, 4'b1011);
      repeat (62) cyc();
      proc_done = 1'b1;
      cyc();
      proc_done = 1'b0;
      check("done_at_last", jump_context_exchange, 1);
      load(2'd1, 12'h555);
      check("single_pulse", jump_context_exchange, 0);
      check("done_mask", active_mask, 4'b1001);
      check("done_next3", next_proc, 3);
      check("done_resume_pc3", resume_pc, p3);

      // Load of another slot together with proc_done
      resume();
      proc_done = 1'b1;
      cyc();
      proc_done = 1'b0;
      cyc();
      check("to0_next", next_proc, 0);
      check("to0_resume_pc", resume_pc, 12'h0A0);
      check("to0_mask", active_mask, 4'b0001);
      resume();
      proc_done = 1'b1; proc_load = 1'b1; proc_load_id = 2'd2; proc_load_pc = 12'h2B0;
      cyc();
      proc_done = 1'b0; proc_load = 1'b0;
      check("load_with_done_mask", active_mask, 4'b0100);
      cyc();
      check("load_with_done_next", next_proc, 2);
      check("load_with_done_resume_pc", resume_pc, 12'h2B0);

      // Sole live slot resumes itself at its captured PC
      resume();
      wait_pulse(n);
      check("slot2_quantum_len", n, 64);
      p = programCounter;
      cyc();
      check("only_slot_next", next_proc, 2);
      check("only_slot_resume_pc", resume_pc, p);

      // Last process exits while halted and disabled; OS resume falls back to idle
      resume();
      HLT = 1'b1; enable = 1'b0; proc_done = 1'b1;
      cyc();
      proc_done = 1'b0; HLT = 1'b0; enable = 1'b1;
      check("done_during_hlt", jump_context_exchange, 1);
      cyc();
      check("last_done_mask", active_mask, 0);
      resume();
      check("last_done_idle", idle, 1);

      // Reset asserted in the middle of the exchange pulse
      load(2'd1, 12'h1C0);
      cyc();
      resume();
      proc_done = 1'b1;
      cyc();
      proc_done = 1'b0;
      check("pre_reset_pulse", jump_context_exchange, 1);
      resetCPU = 1'b0;
      #1;
      check("mid_rst_pulse", jump_context_exchange, 0);
      check("mid_rst_idle", idle, 1);
      check("mid_rst_mask", active_mask, 0);
      check("mid_rst_current", current_proc, 0);
      check("mid_rst_next", next_proc, 0);
      check("mid_rst_saved_pc", saved_pc, 0);
      check("mid_rst_resume_pc", resume_pc, 0);
      repeat (2) cyc();
      resetCPU = 1'b1;
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
